// File: rtl/vl_strip_sequencer.sv
// vl_strip_sequencer: strip-mines one (SEW, LMUL, AVL) command through vl_setup into valid/ready strips
module vl_strip_sequencer #(
    parameter int VLEN = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_sew,
    input  logic [4:0] cmd_lmul,
    input  logic [8:0] cmd_avl,
    input  logic       kill,
    output logic [7:0] vs_sew,
    output logic [4:0] vs_lmul,
    output logic [8:0] vs_avl,
    output logic       vs_valid_sew,
    output logic       vs_valid_lmul,
    input  logic [8:0] vs_vl,
    input  logic [8:0] vs_new_avl,
    output logic       strip_valid,
    input  logic       strip_ready,
    output logic [8:0] strip_vl,
    output logic [8:0] strip_idx,
    output logic       strip_last,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, CALC, ISSUE, FIN} state_t;
    state_t     state_q, state_d;
    logic [7:0] sew_q, sew_d;
    logic [4:0] lmul_q, lmul_d;
    logic [8:0] avl_q, avl_d, idx_q, idx_d, vl_q, vl_d, rem_q, rem_d;
    logic       err_q, err_d;
    logic       legal;
    assign legal = (cmd_sew inside {8'd8, 8'd16, 8'd32, 8'd64, 8'd128})
                && (cmd_lmul inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16})
                && ({24'd0, cmd_sew} <= 32'(VLEN));
    always_comb begin
        state_d = state_q;
        sew_d   = sew_q;
        lmul_d  = lmul_q;
        avl_d   = avl_q;
        idx_d   = idx_q;
        vl_d    = vl_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                sew_d   = cmd_sew;
                lmul_d  = cmd_lmul;
                avl_d   = cmd_avl;
                idx_d   = '0;
                err_d   = !legal;
                state_d = !legal ? IDLE : (cmd_avl == '0) ? FIN : CALC;
            end
            CALC: begin
                vl_d    = vs_vl;
                rem_d   = vs_new_avl;
                state_d = ISSUE;
            end
            ISSUE: if (strip_ready) begin
                avl_d   = rem_q;
                idx_d   = idx_q + vl_q;
                state_d = (rem_q == '0) ? FIN : CALC;
            end
            FIN: state_d = IDLE;
        endcase
        // kill outranks everything, but an accepted strip still advances the pointers
        if (kill && state_q != IDLE) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sew_q   <= '0;
            lmul_q  <= '0;
            avl_q   <= '0;
            idx_q   <= '0;
            vl_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sew_q   <= sew_d;
            lmul_q  <= lmul_d;
            avl_q   <= avl_d;
            idx_q   <= idx_d;
            vl_q    <= vl_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end
    assign cmd_ready     = state_q == IDLE;
    assign vs_sew        = sew_q;
    assign vs_lmul       = lmul_q;
    assign vs_avl        = avl_q;
    assign vs_valid_sew  = state_q == CALC;
    assign vs_valid_lmul = state_q == CALC;
    assign strip_valid   = state_q == ISSUE;
    assign strip_vl      = vl_q;
    assign strip_idx     = idx_q;
    assign strip_last    = state_q == ISSUE && rem_q == '0;
    assign done          = state_q == FIN;
    assign err           = err_q;
endmodule
